// File: rtl/tpu_pkg.sv
// Shared TPU definitions: systolic tile geometry and the weight loader state encoding.
package tpu_pkg;

    localparam int TILE_DIM   = 3;
    localparam int TILE_BYTES = TILE_DIM * TILE_DIM;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/weight_loader_if.sv
// DRAM read port plus weight FIFO column push port of the weight loader.
interface weight_loader_if #(
    parameter int ADDR_W = 24
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    logic              fifo_ready;
    logic              push_col0;
    logic              push_col1;
    logic              push_col2;
    logic [7:0]        push_data;

    modport master (
        output mem_req, mem_addr, push_col0, push_col1, push_col2, push_data,
        input  mem_gnt, mem_rvalid, mem_rdata, fifo_ready
    );

    modport slave (
        input  mem_req, mem_addr, push_col0, push_col1, push_col2, push_data,
        output mem_gnt, mem_rvalid, mem_rdata, fifo_ready
    );

endinterface

// File: rtl/weight_loader.sv
// Streams num_tiles weight tiles byte by byte from DRAM into the per-column weight FIFO,
// one outstanding read at a time.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | DRAM read request held until granted
// WAIT  | waiting for read data
// PUSH  | byte registered, waiting for fifo_ready to push it
// FIN   | job finished, done pulses next cycle
module weight_loader #(
    parameter int TILE_DIM = 3,
    parameter int ADDR_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_tiles,
    output logic              busy,
    output logic              done,
    weight_loader_if.master   bus
);
    import tpu_pkg::*;

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] REQ  = ST_REQ;
    localparam logic [2:0] WAIT = ST_WAIT;
    localparam logic [2:0] PUSH = ST_PUSH;
    localparam logic [2:0] FIN  = ST_FIN;

    localparam logic [7:0] LAST_BYTE = 8'(TILE_DIM * TILE_DIM - 1);
    localparam logic [7:0] DIM_B     = 8'(TILE_DIM);

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] lin_q;
    logic [7:0]        num_q;
    logic [7:0]        tile_q;
    logic [7:0]        byte_q;
    logic [7:0]        data_q;
    logic              done_q;
    logic [7:0]        col;
    logic              push_fire;
    logic [7:0]        tile_next;

    assign push_fire = (state == PUSH) && bus.fifo_ready;
    assign col       = byte_q / DIM_B;
    assign tile_next = tile_q + 8'd1;

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = base_q + lin_q;
    assign bus.push_col0 = push_fire && (col == 8'd0);
    assign bus.push_col1 = push_fire && (col == 8'd1);
    assign bus.push_col2 = push_fire && (col == 8'd2);
    assign bus.push_data = data_q;

    assign busy = (state != IDLE);
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            lin_q  <= '0;
            num_q  <= '0;
            tile_q <= '0;
            byte_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            // done follows FIN by one cycle so it lands after busy has dropped
            done_q <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        num_q  <= num_tiles;
                        lin_q  <= '0;
                        byte_q <= '0;
                        tile_q <= '0;
                        state  <= (num_tiles == 8'd0) ? FIN : REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        data_q <= bus.mem_rdata;
                        state  <= PUSH;
                    end
                end
                PUSH: begin
                    if (bus.fifo_ready) begin
                        lin_q <= lin_q + ADDR_W'(1);
                        if (byte_q == LAST_BYTE) begin
                            byte_q <= '0;
                            tile_q <= tile_next;
                            state  <= (tile_next == num_q) ? FIN : REQ;
                        end else begin
                            byte_q <= byte_q + 8'd1;
                            state  <= REQ;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a memory responder serves reads, a monitor checks
// every grant address and column push against queues filled when each job is issued.
module tb_weight_loader;

    typedef struct {
        logic [1:0] col;
        logic [7:0] data;
    } push_t;

    logic        clk = 1'b0;
    logic        rst_init = 1'b1;
    logic        rst_abort = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [7:0]  num_tiles = '0;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int push_cnt = 0;
    int done_cnt = 0;
    int mem_lat = 1;
    logic abort_req = 1'b0;

    logic [23:0] addr_q[$];
    push_t       push_q[$];

    assign rst = rst_init | rst_abort;

    weight_loader_if #(.ADDR_W(24)) bus ();

    weight_loader #(.TILE_DIM(3), .ADDR_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [23:0] a);
        logic [23:0] d;
        d = a - 24'h0000FF;
        return d[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_job(input logic [23:0] base, input int n);
        logic [23:0] a;
        push_t p;
        for (int i = 0; i < n * 9; i++) begin
            a = base + 24'(i);
            addr_q.push_back(a);
            p.col  = 2'((i % 9) / 3);
            p.data = memf(a);
            push_q.push_back(p);
        end
    endtask

    task automatic start_job(input logic [23:0] base, input logic [7:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_tiles = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 600) begin
            @(posedge clk); #1;
            c++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // memory responder: grant on request, data after mem_lat cycles, optional reset-abort in WAIT
    initial begin
        int phase = 0;
        int cnt = 0;
        logic [23:0] a_l = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            case (phase)
                0: if (bus.mem_req && !rst) begin
                    bus.mem_gnt = 1'b1; a_l = bus.mem_addr; phase = 1;
                end
                1: begin
                    bus.mem_gnt = 1'b0;
                    if (abort_req) begin
                        rst_abort = 1'b1; phase = 4;
                    end else if (mem_lat == 0) begin
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = memf(a_l); phase = 3;
                    end else begin
                        cnt = mem_lat; phase = 2;
                    end
                end
                2: begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = memf(a_l); phase = 3;
                    end
                end
                3: begin
                    bus.mem_rvalid = 1'b0; phase = 0;
                end
                default: begin
                    rst_abort = 1'b0;
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hEE; phase = 3;
                end
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic [2:0]  strobes;
        logic [23:0] exp_a;
        logic [1:0]  col_act;
        push_t       p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_req && bus.mem_gnt) begin
                    if (addr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_grant: addr %06h, none expected", bus.mem_addr);
                    end else begin
                        exp_a = addr_q.pop_front();
                        chk("mem_addr", bus.mem_addr, exp_a);
                    end
                end
                strobes = {bus.push_col2, bus.push_col1, bus.push_col0};
                if (strobes != 3'b000) begin
                    push_cnt++;
                    chk("push_onehot", $countones(strobes), 1);
                    col_act = strobes[2] ? 2'd2 : (strobes[1] ? 2'd1 : 2'd0);
                    if (push_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_push: col %0d data %02h, none expected", col_act, bus.push_data);
                    end else begin
                        p = push_q.pop_front();
                        chk("push_col", col_act, p.col);
                        chk("push_data", bus.push_data, p.data);
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0;
        push_t t1[9];
        logic [23:0] a4[9];
        logic [7:0]  d4[9];
        bus.fifo_ready = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_strobes", {bus.push_col2, bus.push_col1, bus.push_col0}, 3'b000);
        chk("rst_push_data", bus.push_data, 8'h00);
        chk("rst_mem_addr", bus.mem_addr, 24'h000000);
        @(posedge clk); #1;
        rst_init = 1'b0;

        // one tile from 0x100: bytes 01..09 fill col0, col1, col2 in turn
        t1 = '{'{2'd0, 8'h01}, '{2'd0, 8'h02}, '{2'd0, 8'h03},
               '{2'd1, 8'h04}, '{2'd1, 8'h05}, '{2'd1, 8'h06},
               '{2'd2, 8'h07}, '{2'd2, 8'h08}, '{2'd2, 8'h09}};
        for (int i = 0; i < 9; i++) begin
            addr_q.push_back(24'h000100 + 24'(i));
            push_q.push_back(t1[i]);
        end
        p0 = push_cnt; d0 = done_cnt;
        start_job(24'h000100, 8'd1);
        wait_done("t1");
        settle(5);
        chk("t1_pushes", push_cnt - p0, 9);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_busy_after", busy, 1'b0);

        // zero tiles: busy for one cycle, done two cycles after start, no request
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 24'h000777; num_tiles = 8'd0;
        @(negedge clk);
        chk("z_start_cycle_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("z_busy_c1", busy, 1'b1);
        chk("z_done_c1", done, 1'b0);
        chk("z_req_c1", bus.mem_req, 1'b0);
        @(negedge clk);
        chk("z_busy_c2", busy, 1'b0);
        chk("z_done_c2", done, 1'b1);
        chk("z_req_c2", bus.mem_req, 1'b0);
        @(negedge clk);
        chk("z_done_c3", done, 1'b0);
        settle(3);
        chk("z_done_count", done_cnt - d0, 1);

        // two tiles from 0x200 with a FIFO stall on byte 4
        expect_job(24'h000200, 2);
        p0 = push_cnt; d0 = done_cnt;
        start_job(24'h000200, 8'd2);
        begin
            int c = 0;
            while (push_cnt < p0 + 4 && c < 200) begin
                @(posedge clk); #1;
                c++;
            end
        end
        chk("s_reached_byte4", push_cnt - p0, 4);
        bus.fifo_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("s_stall_strobes", {bus.push_col2, bus.push_col1, bus.push_col0}, 3'b000);
            if (i >= 3) chk("s_stall_data", bus.push_data, 8'h05);
        end
        @(posedge clk); #1;
        bus.fifo_ready = 1'b1;
        wait_done("s");
        settle(5);
        chk("s_pushes", push_cnt - p0, 18);
        chk("s_done_count", done_cnt - d0, 1);

        // address wrap from 0xFFFFFC
        a4 = '{24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF,
               24'h000000, 24'h000001, 24'h000002, 24'h000003, 24'h000004};
        d4 = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 9; i++) begin
            push_t p;
            p.col = 2'(i / 3);
            p.data = d4[i];
            addr_q.push_back(a4[i]);
            push_q.push_back(p);
        end
        mem_lat = 0;
        p0 = push_cnt;
        start_job(24'hFFFFFC, 8'd1);
        wait_done("w");
        settle(3);
        chk("w_pushes", push_cnt - p0, 9);
        mem_lat = 2;

        // reset in WAIT with read data arriving the following cycle
        addr_q.push_back(24'h000400);
        p0 = push_cnt; d0 = done_cnt;
        abort_req = 1'b1;
        start_job(24'h000400, 8'd1);
        settle(12);
        abort_req = 1'b0;
        chk("a_pushes", push_cnt - p0, 0);
        chk("a_done_count", done_cnt - d0, 0);
        chk("a_busy", busy, 1'b0);
        chk("a_addr_pending", addr_q.size(), 0);

        // clean job after the abort
        expect_job(24'h000600, 1);
        p0 = push_cnt; d0 = done_cnt;
        start_job(24'h000600, 8'd1);
        wait_done("r");
        settle(3);
        chk("r_pushes", push_cnt - p0, 9);
        chk("r_done_count", done_cnt - d0, 1);

        // start while busy is ignored
        mem_lat = 1;
        expect_job(24'h000300, 1);
        p0 = push_cnt; d0 = done_cnt;
        start_job(24'h000300, 8'd1);
        settle(6);
        chk("i_busy_mid", busy, 1'b1);
        start = 1'b1; base_addr = 24'h000500; num_tiles = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("i");
        settle(30);
        chk("i_pushes", push_cnt - p0, 9);
        chk("i_done_count", done_cnt - d0, 1);
        chk("i_busy_end", busy, 1'b0);

        chk("end_addr_q_left", addr_q.size(), 0);
        chk("end_push_q_left", push_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
